// File: rtl/sram_responder.sv
// sram_responder: behavioural-synthesizable stand-in for the external 16-bit
//   asynchronous-style SRAM on the memory controller's RAM port.
// Latency: writes land in the array at the sampling edge and are readable by
//   a read sampled on the next edge. Read data is driven READ_LATENCY-1 edges
//   after the sampling edge and held for one cycle.
// Backpressure: none; one access per cycle, fully pipelined reads. The bus
//   driver releases combinationally as soon as mc_ram_wre falls.
//
// Parameters:
//   ADDR_WIDTH   - width of mc_ram_addr (word address)
//   DATA_WIDTH   - width of the shared data bus
//   DEPTH_LOG2   - log2 of implemented words; upper address bits alias
//   READ_LATENCY - edges from read sample to data on bus, legal 1..4
//
// Ports:
//   clock, reset            - posedge clock, asynchronous active-low reset
//   mc_ram_addr             - word address from the controller
//   mc_ram_wre              - 0 = write, 1 = read (idle cycles are reads)
//   mc_ram_data             - bidirectional bus, driven only in read data phase
//   ram_rd_count            - saturating count of read samples
//   ram_wr_count            - saturating count of writes
//   ram_conflict            - sticky: write arrived while read data was on bus

module sram_responder #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mc_ram_addr,
  input  logic                  mc_ram_wre,
  inout  wire  [DATA_WIDTH-1:0] mc_ram_data,
  output logic [15:0]           ram_rd_count,
  output logic [15:0]           ram_wr_count,
  output logic                  ram_conflict
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAST  = READ_LATENCY - 1;

  // ---------------------------------------------------------------------------
  // Address decode. Upper address bits are deliberately ignored so that the
  // array aliases modulo 2^DEPTH_LOG2, like a board SRAM with floating pins.
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_addr_hi;

  assign mem_idx        = mc_ram_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mc_ram_addr[ADDR_WIDTH-1:DEPTH_LOG2];

  // Every wre==1 cycle is a read, including idle cycles; this keeps the read
  // path free-running and means the controller never has to flag "idle".
  assign wr_en = ~mc_ram_wre;
  assign rd_en = mc_ram_wre;

  // ---------------------------------------------------------------------------
  // Storage array. Not touched by reset so that contents survive a reset
  // pulse, matching the real part. Writes are ignored while reset is held.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset && wr_en) begin
      mem_q[mem_idx] <= mc_ram_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Stage 0 captures the array word at the sampling edge, so a
  // write on a later edge cannot disturb data already in flight. Each stage
  // carries a valid bit; only the valid bits need the asynchronous reset.
  // ---------------------------------------------------------------------------
  logic                  rd_vld_q [READ_LATENCY];
  logic                  rd_vld_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd_dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd_dat_d [READ_LATENCY];

  always_comb begin
    for (int s = 0; s < READ_LATENCY; s++) begin
      rd_vld_d[s] = 1'b0;
      rd_dat_d[s] = rd_dat_q[s];
    end
    rd_vld_d[0] = rd_en;
    if (rd_en) begin
      rd_dat_d[0] = mem_q[mem_idx];
    end
    for (int s = 1; s < READ_LATENCY; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_dat_d[s] = rd_dat_q[s-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        rd_vld_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        rd_vld_q[s] <= rd_vld_d[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < READ_LATENCY; s++) begin
      rd_dat_q[s] <= rd_dat_d[s];
    end
  end

  // ---------------------------------------------------------------------------
  // Bus driver. The wre term is combinational on purpose: when the controller
  // pulls wre low to start a write, this block lets go of the bus in the same
  // cycle, giving zero-cycle turnaround without overlapping drivers.
  // ---------------------------------------------------------------------------
  logic drive_en;

  assign drive_en    = rd_vld_q[LAST] & mc_ram_wre;
  assign mc_ram_data = drive_en ? rd_dat_q[LAST] : {DATA_WIDTH{1'bz}};

  // ---------------------------------------------------------------------------
  // Access counters (saturating) and the sticky conflict flag. A conflict is
  // a write edge that finds read data sitting in the last stage: that data was
  // never consumed and is dropped as the pipeline advances.
  // ---------------------------------------------------------------------------
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        conflict_q, conflict_d;

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    conflict_d = conflict_q;
    if (rd_en && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (wr_en && rd_vld_q[LAST]) begin
      conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q   <= 16'd0;
      wr_cnt_q   <= 16'd0;
      conflict_q <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign ram_rd_count = rd_cnt_q;
  assign ram_wr_count = wr_cnt_q;
  assign ram_conflict = conflict_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: drives two responders (READ_LATENCY 1 and 3) with the
//   same controller cycles and checks bus, counters and conflict every cycle
//   against an edge-indexed access model, plus hand-computed literal points.
// Released bus reads back as all-ones through the pull-up on the net.

module tb_sram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] addr  = 18'd5;
  logic        wre   = 1'b0;
  logic [15:0] tb_dat = 16'hBEEF;
  bit          chk_en = 1'b0;

  tri1 [15:0] bus1;
  tri1 [15:0] bus3;

  // The controller side drives the bus only during write cycles.
  assign bus1 = wre ? 16'hzzzz : tb_dat;
  assign bus3 = wre ? 16'hzzzz : tb_dat;

  logic [15:0] rd1, wr1, rd3, wr3;
  logic        cf1, cf3;

  always #5 clock = ~clock;

  sram_responder #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .DEPTH_LOG2(10), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mc_ram_addr(addr), .mc_ram_wre(wre),
    .mc_ram_data(bus1), .ram_rd_count(rd1), .ram_wr_count(wr1), .ram_conflict(cf1)
  );

  sram_responder #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .DEPTH_LOG2(10), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .mc_ram_addr(addr), .mc_ram_wre(wre),
    .mc_ram_data(bus3), .ram_rd_count(rd3), .ram_wr_count(wr3), .ram_conflict(cf3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: every sampling edge is numbered. A read sampled at edge e is on the
  // bus after edge e+L-1 (if wre is high); a write at edge m conflicts if a
  // read was sampled at edge m-L. Reset forgets all reads.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          e;
    logic [15:0] d;
    bit          k;
  } rec_t;

  rec_t        rq[$];
  logic [15:0] m_mem [1024];
  bit          m_known [1024];
  int          m_edge = 0;
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_cf [2];
  int          lat [2] = '{1, 3};
  rec_t        m_r;

  function automatic bit find_rec(input int e, output rec_t r);
    r = '{0, 16'h0, 1'b0};
    foreach (rq[i]) begin
      if (rq[i].e == e) begin
        r = rq[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rq.delete();
      m_rd = 0;
      m_wr = 0;
      m_cf[0] = 1'b0;
      m_cf[1] = 1'b0;
    end else begin
      m_edge++;
      if (!wre) begin
        for (int i = 0; i < 2; i++) begin
          if (find_rec(m_edge - lat[i], m_r)) m_cf[i] = 1'b1;
        end
        m_mem[addr[9:0]]   = tb_dat;
        m_known[addr[9:0]] = 1'b1;
        if (m_wr < 65535) m_wr++;
      end else begin
        rq.push_back('{m_edge, m_mem[addr[9:0]], m_known[addr[9:0]]});
        if (m_rd < 65535) m_rd++;
      end
      while (rq.size() > 0 && rq[0].e < m_edge - 4) void'(rq.pop_front());
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] bus_v;
        rec_t        r;
        bus_v = (i == 0) ? bus1 : bus3;
        if (!wre) begin
          chk((i == 0) ? "bus1_wr_phase" : "bus3_wr_phase", bus_v, tb_dat);
        end else if (find_rec(m_edge - lat[i] + 1, r)) begin
          if (r.k) chk((i == 0) ? "bus1_rd_data" : "bus3_rd_data", bus_v, r.d);
        end else begin
          chk((i == 0) ? "bus1_released" : "bus3_released", bus_v, 16'hFFFF);
        end
      end
      chk("rd_count1", rd1, m_rd[15:0]);
      chk("wr_count1", wr1, m_wr[15:0]);
      chk("rd_count3", rd3, m_rd[15:0]);
      chk("wr_count3", wr3, m_wr[15:0]);
      chk("conflict1", {15'd0, cf1}, {15'd0, m_cf[0]});
      chk("conflict3", {15'd0, cf3}, {15'd0, m_cf[1]});
    end
  end

  task automatic drive(input logic w, input logic [17:0] a, input logic [15:0] d);
    wre    = w;
    addr   = a;
    tb_dat = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 chk_en = 1'b1;

    // Reset held low for two edges.
    tick();
    tick();
    chk("rst_rd1", rd1, 16'd0);
    chk("rst_wr1", wr1, 16'd0);
    chk("rst_conflict1", {15'd0, cf1}, 16'd0);
    drive(1'b1, 18'd5, 16'h0000);
    #1 chk("rst_bus1_z", bus1, 16'hFFFF);
    chk("rst_bus3_z", bus3, 16'hFFFF);
    tick();

    // Write BEEF to 5 on the first edge after release, read it back next edge.
    drive(1'b0, 18'd5, 16'hBEEF);
    reset = 1'b1;
    tick();
    drive(1'b1, 18'd5, 16'h0000);
    tick();
    drive(1'b1, 18'd5, 16'h0000);
    #1 chk("raw_bus1", bus1, 16'hBEEF);
    chk("raw_wr1", wr1, 16'd1);
    chk("raw_rd1", rd1, 16'd1);

    // Reset pulse while read data is on the bus: released immediately.
    reset = 1'b0;
    #1 chk("midrst_bus1_z", bus1, 16'hFFFF);
    chk("midrst_bus3_z", bus3, 16'hFFFF);
    chk("midrst_rd1", rd1, 16'd0);
    reset = 1'b1;
    tick();

    // Aliasing: 0x403 hits the same word as 0x003.
    drive(1'b0, 18'h00003, 16'h1234);
    tick();
    drive(1'b1, 18'h00403, 16'h0000);
    tick();
    drive(1'b1, 18'h00403, 16'h0000);
    #1 chk("alias_bus1", bus1, 16'h1234);
    tick();

    // Preload 0..3, then stream reads; latency-3 data on four back-to-back cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 18'(i), 16'h0010 + 16'(i));
      tick();
    end
    drive(1'b1, 18'd0, 16'h0000); tick();
    drive(1'b1, 18'd1, 16'h0000); tick();
    drive(1'b1, 18'd2, 16'h0000); tick();
    drive(1'b1, 18'd3, 16'h0000);
    #1 chk("stream3_0", bus3, 16'h0010);
    tick();
    drive(1'b1, 18'd3, 16'h0000);
    #1 chk("stream3_1", bus3, 16'h0011);
    tick();
    drive(1'b1, 18'd0, 16'h0000);
    #1 chk("stream3_2", bus3, 16'h0012);
    tick();
    drive(1'b1, 18'd0, 16'h0000);
    #1 chk("stream3_3", bus3, 16'h0013);
    tick();

    // Turnaround: read 7 then write 7 on the very next edge.
    drive(1'b0, 18'd7, 16'h5555);
    tick();
    drive(1'b1, 18'd7, 16'h0000);
    tick();
    drive(1'b1, 18'd7, 16'h0000);
    #1 chk("turn_bus1_rd", bus1, 16'h5555);
    drive(1'b0, 18'd7, 16'hAAAA);
    #1 chk("turn_bus1_release", bus1, 16'hAAAA);
    tick();
    chk("turn_conflict1", {15'd0, cf1}, 16'd1);
    drive(1'b1, 18'd7, 16'h0000);
    tick();
    drive(1'b1, 18'd7, 16'h0000);
    #1 chk("turn_bus1_new", bus1, 16'hAAAA);
    chk("turn_conflict1_sticky", {15'd0, cf1}, 16'd1);
    for (int i = 0; i < 4; i++) tick();

    // Saturation of the read counter.
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 18'(i % 4), 16'h0000);
      tick();
    end
    chk("sat_rd1", rd1, 16'hFFFF);
    chk("sat_rd3", rd3, 16'hFFFF);
    chk("sat_conflict1", {15'd0, cf1}, 16'd1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Behavioural-synthesizable model of the external 16-bit asynchronous-style SRAM that sits on the far end of the memory controller's RAM port (mc_ram_addr / mc_ram_wre / mc_ram_data). It answers the controller's write and read cycles, drives read data back onto the shared bidirectional bus after a configurable latency, and exposes access counters and a contention flag for verification. It is used in the controller benches and at system level in place of the board SRAM.

## Interface
- ADDR_WIDTH, 18: width of mc_ram_addr.
- DATA_WIDTH, 16: width of mc_ram_data.
- DEPTH_LOG2, 10: log2 of implemented words; upper address bits are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- READ_LATENCY, 1: clock edges from read sample to data on bus; legal 1..4.
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- mc_ram_addr  in  ADDR_WIDTH  word address from the controller.
- mc_ram_wre  in  1  write enable, active-low: 0 = write, 1 = read/idle.
- mc_ram_data  inout  DATA_WIDTH  shared data bus; driven by this block only during read data phase, else Z.
- ram_rd_count  out  16  number of read samples accepted, saturating.
- ram_wr_count  out  16  number of writes performed, saturating.
- ram_conflict  out  1  sticky: a write arrived while read data was pending on the bus.

## Operation
- Array: 2^DEPTH_LOG2 words of DATA_WIDTH; index = mc_ram_addr[DEPTH_LOG2-1:0]. Contents not cleared by reset.
- Write: at posedge with mc_ram_wre==0, mem[index] <= mc_ram_data; ram_wr_count increments.
- Read: at posedge with mc_ram_wre==1, mem[index] is captured into stage 0 of a READ_LATENCY-deep pipeline with a valid bit; ram_rd_count increments. Data is captured at the sampling edge; later writes do not alter in-flight data.
- Every wre==1 cycle is a read (idle reads are harmless); throughput one read per cycle, fully pipelined.
- Bus driver: drive_en = valid[last stage] AND mc_ram_wre==1; mc_ram_data = drive_en ? data[last] : Z. The wre term is combinational so the driver releases in the same cycle the controller pulls wre low (zero-cycle turnaround, no contention).
- Conflict: at posedge with wre==0 and valid[last]==1, ram_conflict <= 1 (read data discarded); stays 1 until reset.
- Read-after-write same address: write at edge N, read sampled at edge N+1 returns the new value.
- Counters saturate at 16'hFFFF; no wrap.
- Reset asserted (low), any time including mid-pipeline: all valid bits cleared immediately, mc_ram_data Z, counters 0, ram_conflict 0. Array untouched. First sample after reset release on next posedge with reset high.

## Timing
- Outputs at reset: mc_ram_data Z, ram_rd_count 0, ram_wr_count 0, ram_conflict 0.
- Write latency: array updated at the sampling edge; readable by a read sampled at the next edge.
- Read latency: address sampled at edge N; data driven from edge N+READ_LATENCY-1 (plus clk-to-q) until edge N+READ_LATENCY, provided wre stays 1. READ_LATENCY=1: data visible in the cycle after the sampling edge.
- Back-to-back reads A0,A1,A2 at edges N..N+2 produce data on consecutive cycles, no bubbles.
- Write sampled at edge M with read sampled at edge M-1 and READ_LATENCY=1: bus released as soon as wre falls in cycle M-1→M; ram_conflict set at edge M.

## Test plan
- Reset: hold reset low 2 cycles -> mc_ram_data Z, both counters 0, ram_conflict 0; pulse reset low mid-read -> bus Z within same cycle, valid cleared.
- Write/read, latency 1: write 16'hBEEF to addr 5 (wre=0), next edge read addr 5 -> bus 16'hBEEF the following cycle; ram_wr_count 1, ram_rd_count 1.
- Aliasing: DEPTH_LOG2=10, write 16'h1234 to addr 18'h00003, read 18'h00403 -> 16'h1234.
- Streaming, READ_LATENCY=3: preload addrs 0..3 with 16'h0010..16'h0013, read 0..3 on consecutive edges -> data 16'h0010..16'h0013 on four consecutive cycles starting 2 cycles after the first sample edge.
- Turnaround/conflict: read addr 7 then write 16'hAAAA to addr 7 on the very next edge -> bus Z as soon as wre falls, ram_conflict=1 and sticky, subsequent read addr 7 returns 16'hAAAA.
- Saturation: force 65540 reads -> ram_rd_count holds 16'hFFFF.
